// File: rtl/dm_pkg.sv
// Shared encodings for the data memory controller: access types, FSM states
// and the access-legality check used by the top level.
package dm_pkg;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misalignment, unknown encodings and unsigned stores are rejected; range is checked by the caller.
    function automatic logic type_fault(input logic we, input logic [2:0] acc_type,
                                        input logic [1:0] addr_lo);
        logic f;
        case (acc_type)
            TYPE_B:  f = 1'b0;
            TYPE_H:  f = addr_lo[0];
            TYPE_W:  f = (addr_lo != 2'b00);
            TYPE_BU: f = we;
            TYPE_HU: f = we | addr_lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load extraction
// with sign or zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  acc_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata_word >> {addr_lo, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wlanes    = wdata;
        load_data = 32'h0;
        case (acc_type)
            TYPE_B: begin
                be        = 4'b0001 << addr_lo;
                wlanes    = {4{wdata[7:0]}};
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            TYPE_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wlanes    = {2{wdata[15:0]}};
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            TYPE_W: begin
                be        = 4'b1111;
                load_data = rdata_word;
            end
            TYPE_BU: load_data = {24'h0, shifted[7:0]};
            TYPE_HU: load_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access, a fixed access
// latency and a single-cycle response strobe.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, next_state;
    logic [2:0]  cnt, next_cnt;
    logic        we_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        accept, do_access, fault, in_range;
    logic [AW-1:0] word_idx;
    logic [31:0] mem_word, wlanes, load_data;
    logic [3:0]  be;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state != ST_WAIT);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign do_access = (state == ST_WAIT) && (cnt == 3'd0);
    assign in_range  = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
    assign fault     = type_fault(we_q, type_q, addr_q[1:0]) || !in_range;
    assign word_idx  = addr_q[AW+1:2];
    assign mem_word  = mem[word_idx];
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_fault = rsp_valid ? fault_q : 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (req_valid) begin
                    next_state = ST_WAIT;
                    next_cnt   = 3'(LATENCY - 1);
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) next_state = ST_RESP;
                else             next_cnt   = cnt - 3'd1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            type_q  <= TYPE_W;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response data is captured on the access edge; stores and faults return zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (do_access) begin
            fault_q <= fault;
            rdata_q <= (fault || we_q) ? 32'h0 : load_data;
        end
    end

    // Storage is never reset; an abandoned request cannot reach this write because reset leaves WAIT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_access && we_q && !fault && be[i])
                mem[word_idx][i*8 +: 8] <= wlanes[i*8 +: 8];
        end
    end

    dm_lane_align u_align (
        .acc_type   (type_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata_word (mem_word),
        .be         (be),
        .wlanes     (wlanes),
        .load_data  (load_data)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: three controllers (LATENCY 2, 1, 8) share clock and reset;
// expected responses are queued at acceptance and checked by a monitor.
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc_cyc;
        string       name;
    } exp_t;

    logic        clk, rstn;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [2:0]  req_type  [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_fault [3];

    exp_t exp_q [3][$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   waited;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 8;
    endfunction

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_fault(rsp_fault[0]));

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_fault(rsp_fault[1]));

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(8)) dut_l8 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[2]), .req_we(req_we[2]),
        .req_type(req_type[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_fault(rsp_fault[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic print_summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Monitor: every response is matched in order against the queue, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d]) begin
                if (exp_q[d].size() == 0) begin
                    check_output($sformatf("dut%0d unexpected rsp_valid", d), 32'd1, 32'd0);
                end else begin
                    e = exp_q[d].pop_front();
                    check_output({e.name, " rdata"}, rsp_rdata[d], e.rdata);
                    check_output({e.name, " fault"}, 32'(rsp_fault[d]), 32'(e.fault));
                    check_output({e.name, " rsp cycle"}, 32'(cyc), 32'(e.acc_cyc + lat_of(d)));
                end
            end else begin
                check_output($sformatf("dut%0d idle rdata", d), rsp_rdata[d], 32'h0);
                check_output($sformatf("dut%0d idle fault", d), 32'(rsp_fault[d]), 32'h0);
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge, valid still high.
    task automatic apply_stimulus(input int d, input logic we, input logic [2:0] t,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] er, input logic ef, input string name,
                                  input bit expect_rsp, output int nwait);
        exp_t e;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_type[d]  = t;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        nwait = 0;
        while (!req_ready[d] && nwait < 100) begin
            @(negedge clk);
            nwait++;
        end
        if (!req_ready[d]) begin
            check_output({name, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        if (expect_rsp) begin
            e.rdata = er; e.fault = ef; e.acc_cyc = cyc + 1; e.name = name;
            exp_q[d].push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_output({name, " ready low in WAIT"}, 32'(req_ready[d]), 32'd0);
    endtask

    task automatic go_idle(input int d);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'b0;
        req_addr[d]  = 32'hFFFF_FFFC;
        req_wdata[d] = 32'hFFFF_FFFF;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (exp_q[d].size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("dut%0d queue drained", d), 32'(exp_q[d].size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic single(input int d, input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ef,
                          input string name);
        int nw;
        apply_stimulus(d, we, t, a, wd, er, ef, name, 1'b1, nw);
        go_idle(d);
        wait_drain(d);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        n_fail++;
        print_summary();
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            go_idle(d);
            req_type[d] = 3'b010;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_output($sformatf("dut%0d reset ready", d), 32'(req_ready[d]), 32'd1);
            check_output($sformatf("dut%0d reset valid", d), 32'(rsp_valid[d]), 32'd0);
            check_output($sformatf("dut%0d reset rdata", d), rsp_rdata[d], 32'h0);
            check_output($sformatf("dut%0d reset fault", d), 32'(rsp_fault[d]), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] basic word/byte accesses, latency 2");
        single(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw 0x10");
        single(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw 0x10");
        single(0, 1, 3'b000, 32'h11, 32'hFFFF_FF80, 32'h0, 0, "sb 0x11");
        single(0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0, "lb 0x11");
        single(0, 0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0, "lbu 0x11");
        single(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, "lw after sb");

        $display("[TB] faulting accesses");
        single(0, 0, 3'b001, 32'h13, 32'h0, 32'h0, 1, "lh misaligned");
        single(0, 1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1, "sw misaligned");
        single(0, 0, 3'b010, DEPTH * 4, 32'h0, 32'h0, 1, "lw out of range");
        single(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "bad type 011");
        single(0, 1, 3'b100, 32'h10, 32'h22, 32'h0, 1, "unsigned store");
        single(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, "lw unchanged");

        $display("[TB] back-to-back requests with valid held");
        apply_stimulus(0, 1, 3'b001, 32'h16, 32'h7777A5C3, 32'h0, 0, "b2b sh 0x16", 1, waited);
        apply_stimulus(0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFFA5C3, 0, "b2b lh 0x16", 1, waited);
        check_output("b2b wait 2", 32'(waited), 32'd2);
        apply_stimulus(0, 0, 3'b101, 32'h16, 32'h0, 32'h0000A5C3, 0, "b2b lhu 0x16", 1, waited);
        check_output("b2b wait 3", 32'(waited), 32'd2);
        apply_stimulus(0, 0, 3'b000, 32'h17, 32'h0, 32'hFFFFFFA5, 0, "b2b lb 0x17", 1, waited);
        check_output("b2b wait 4", 32'(waited), 32'd2);
        go_idle(0);
        wait_drain(0);

        $display("[TB] reset during WAIT abandons a store");
        single(0, 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, "sw 0 @0x20");
        apply_stimulus(0, 1, 3'b010, 32'h20, 32'h12345678, 32'h0, 0, "aborted sw", 0, waited);
        rstn = 1'b0;
        go_idle(0);
        @(negedge clk);
        check_output("reset in WAIT valid", 32'(rsp_valid[0]), 32'd0);
        check_output("reset in WAIT ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        single(0, 0, 3'b010, 32'h20, 32'h0, 32'h0, 0, "lw 0x20 after abort");

        $display("[TB] latency 1 and 8 builds");
        for (int d = 1; d < 3; d++) begin
            single(d, 1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 0, $sformatf("dut%0d sw 0x8", d));
            single(d, 0, 3'b010, 32'h8, 32'h0, 32'hCAFEF00D, 0, $sformatf("dut%0d lw 0x8", d));
            single(d, 0, 3'b101, 32'hA, 32'h0, 32'h0000CAFE, 0, $sformatf("dut%0d lhu 0xA", d));
        end

        repeat (12) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check_output($sformatf("dut%0d final queue", d), 32'(exp_q[d].size()), 32'd0);
        print_summary();
        $finish;
    end

endmodule
